// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, channel FSM states and a byte-strobe merge helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest supported data bus; narrower callers zero-extend into these widths.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] new_val,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register bank with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        NUM_REGS       = 16,
  parameter logic [AXI_DATA_WIDTH-1:0] REG_RESET      = '0
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                               s_axil_awvalid,
  output logic                               s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                               s_axil_wvalid,
  output logic                               s_axil_wready,
  output logic [1:0]                         s_axil_bresp,
  output logic                               s_axil_bvalid,
  input  logic                               s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                reg_wr_stb
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int FIELD_W  = AXI_ADDR_WIDTH - ADDR_LSB;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------- decode
  logic [FIELD_W-1:0] aw_field, ar_field;
  logic               aw_ok_in, ar_ok_in;
  logic [IDX_W-1:0]   aw_idx_in, ar_idx_in;

  assign aw_field  = s_axil_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_field  = s_axil_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign aw_ok_in  = aw_field < FIELD_W'(NUM_REGS);
  assign ar_ok_in  = ar_field < FIELD_W'(NUM_REGS);
  assign aw_idx_in = aw_field[IDX_W-1:0];
  assign ar_idx_in = ar_field[IDX_W-1:0];

  // ---------------------------------------------------------------- write path
  wr_state_t             wr_state;
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  aw_ok_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs, w_hs, commit;
  logic [IDX_W-1:0]      c_idx;
  logic                  c_ok;
  logic [AXI_DATA_WIDTH-1:0] c_data, merged;
  logic [STRB_W-1:0]     c_strb;
  logic [MAX_DATA_W-1:0] old_ext, new_ext, merged_ext;
  logic [MAX_STRB_W-1:0] strb_ext;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  // A commit can use a held beat, a beat arriving this edge, or one of each.
  assign commit = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign c_idx  = aw_held ? aw_idx_q : aw_idx_in;
  assign c_ok   = aw_held ? aw_ok_q  : aw_ok_in;
  assign c_data = w_held  ? wdata_q  : s_axil_wdata;
  assign c_strb = w_held  ? wstrb_q  : s_axil_wstrb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    old_ext  = '0;
    new_ext  = '0;
    strb_ext = '0;
    old_ext[AXI_DATA_WIDTH-1:0] = regs[c_idx];
    new_ext[AXI_DATA_WIDTH-1:0] = c_data;
    strb_ext[STRB_W-1:0]        = c_strb;
    merged_ext = strb_merge(old_ext, new_ext, strb_ext);
  end

  assign merged = merged_ext[AXI_DATA_WIDTH-1:0];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state       <= W_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_idx_q       <= '0;
      aw_ok_q        <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      reg_wr_stb     <= '0;
      // NOTE: this array is software-visible state with a defined reset value, so it is
      // reset element by element; scratch RAMs without that contract are left unreset.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read of
      // regs/holds in this edge sees the pre-edge value.
      reg_wr_stb <= '0;
      unique case (wr_state)
        W_IDLE: begin
          if (commit) begin
            if (c_ok) begin
              regs[c_idx]       <= merged;
              reg_wr_stb[c_idx] <= 1'b1;
            end
            s_axil_bresp   <= c_ok ? RESP_OKAY : OOR_RESP;
            s_axil_bvalid  <= 1'b1;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            aw_held        <= 1'b1;
            w_held         <= 1'b1;
            wr_state       <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= aw_idx_in;
              aw_ok_q  <= aw_ok_in;
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= s_axil_wdata;
              wstrb_q <= s_axil_wstrb;
            end
            s_axil_awready <= !(aw_held || aw_hs);
            s_axil_wready  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            wr_state       <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- read path
  rd_state_t rd_state;
  logic      ar_hs;

  assign ar_hs = s_axil_arvalid && s_axil_arready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state       <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axil_rdata   <= ar_ok_in ? regs[ar_idx_in] : '0;
            s_axil_rresp   <= ar_ok_in ? RESP_OKAY : OOR_RESP;
            s_axil_rvalid  <= 1'b1;
            s_axil_arready <= 1'b0;
            rd_state       <= R_RESP;
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            rd_state       <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- user-side view
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
  end

  // Sub-word address bits and the widened merge bits above the bus width carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0], merged_ext};

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile: directed cases plus randomized traffic against an array model.
module tb_axil_slave_regfile;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic              aclk = 1'b0;
  logic              areset;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*DW-1:0]  regs_o;
  logic [NR-1:0]     reg_wr_stb;

  always #5 aclk = ~aclk;

  axil_slave_regfile #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .NUM_REGS      (NR),
    .REG_RESET     ('0)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axil_awaddr (awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata  (wdata),
    .s_axil_wstrb  (wstrb),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_bresp  (bresp),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata  (rdata),
    .s_axil_rresp  (rresp),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready),
    .regs_o        (regs_o),
    .reg_wr_stb    (reg_wr_stb)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [NR];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = model[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v, new_v,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < DW/8; b++) if (strb[b]) mask = mask | (32'hFF << (8*b));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (a >> 2) < 32'd16;
  endfunction

  // Full write transaction: AW issued aw_lag cycles in, W issued w_lag cycles in, B stalled b_stall cycles.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_lag, input int w_lag, input int b_stall);
    bit aw_done, w_done, aw_fire, w_fire, ok;
    int c, idx;
    logic [1:0]    exp_resp;
    logic [NR-1:0] exp_stb;
    aw_done = 0; w_done = 0; c = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 60) begin
      awvalid = !aw_done && (c >= aw_lag);
      wvalid  = !w_done && (c >= w_lag);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_accept", aw_done, 1'b1);
    check("w_accept", w_done, 1'b1);
    ok  = addr_ok(a);
    idx = int'(a[AW-1:2]);
    exp_stb = '0;
    if (ok) begin
      model[idx] = byte_merge(model[idx], d, s);
      exp_stb[idx] = 1'b1;
    end
    exp_resp = ok ? 2'b00 : EXP_OOR;
    check("bvalid_latency", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    check("wr_stb_pulse", reg_wr_stb, exp_stb);
    check("regs_after_wr", regs_o, model_flat());
    check("awready_busy", {awready, wready}, 2'b00);
    bready = 1'b0;
    for (int i = 0; i < b_stall; i++) begin
      tick();
      check("bvalid_stall", bvalid, 1'b1);
      check("bresp_stall", bresp, exp_resp);
      check("wr_stb_single", reg_wr_stb, '0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
    check("wr_stb_idle", reg_wr_stb, '0);
    check("wready_back", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int r_stall);
    bit fire, done, ok;
    int c;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_r;
    ok    = addr_ok(a);
    exp_d = ok ? model[int'(a[AW-1:2])] : '0;
    exp_r = ok ? 2'b00 : EXP_OOR;
    araddr = a; arvalid = 1'b1; done = 0; c = 0;
    while (!done && c < 60) begin
      fire = arready;
      tick();
      done = fire;
      c++;
    end
    arvalid = 1'b0;
    check("ar_accept", done, 1'b1);
    check("rvalid_latency", rvalid, 1'b1);
    check("rdata", rdata, exp_d);
    check("rresp", rresp, exp_r);
    for (int i = 0; i < r_stall; i++) begin
      tick();
      check("rstall_state", {rvalid, arready, rresp}, {1'b1, 1'b0, exp_r});
      check("rdata_stable", rdata, exp_d);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] held_d;
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid, bresp, rresp}, 6'b0);
    check("rst_rdata", rdata, '0);
    check("rst_stb", reg_wr_stb, '0);
    check("rst_regs", regs_o, model_flat());
    areset = 1'b0;
    tick();
    check("readies_after_rst", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);

    // Directed writes
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg2_value", regs_o[2*DW +: DW], 32'hDEADBEEF);
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h0C, 32'h11223344, 4'h5, 3, 0, 4);
    check("w_first_merge", regs_o[3*DW +: DW], 32'hAA22CC44);
    do_write(32'h40, 32'h12345678, 4'hF, 1, 0, 2);
    do_write(32'h14, 32'hCAFEF00D, 4'h0, 0, 2, 0);
    do_read(32'h40, 2);

    // Read lands on the same edge as a write commit to the same register
    do_write(32'h08, 32'h1, 4'hF, 0, 0, 0);
    awaddr = 32'h08; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h08;
    check("sim_ready", {awready, wready, arready}, 3'b111);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[2] = 32'h5;
    check("sim_resp_valid", {bvalid, rvalid}, 2'b11);
    check("sim_old_data", rdata, 32'h1);
    check("sim_stb", reg_wr_stb, 16'h0004);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("sim_done", {bvalid, rvalid}, 2'b00);
    do_read(32'h08, 1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      ra = AW'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra[AW-1] = 1'b1;
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(ra, $urandom_range(0, 3));
    end
    check("regs_after_random", regs_o, model_flat());

    // Reset while a read response is pending
    do_write(32'h08, 32'h0BADF00D, 4'hF, 0, 0, 0);
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    held_d = rdata;
    check("mid_rd_valid", rvalid, 1'b1);
    check("mid_rd_data", held_d, 32'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_rd_stall", {rvalid, arready}, 2'b10);
      check("mid_rd_stable", rdata, held_d);
    end
    areset = 1'b1;
    tick();
    check("rst_drops_rvalid", rvalid, 1'b0);
    areset = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    check("regs_after_rerst", regs_o, model_flat());
    check("readies_after_rerst", {awready, wready, arready}, 3'b111);
    do_read(32'h08, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
